// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider producing one quotient bit per cycle.
// Define DIV_SIGNED_EN to add two's complement (DIV) support; otherwise every op is unsigned.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // S_FIX is the result stage: sign fix-up and output registration before S_DONE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             zero_div_s;

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dz_r;

    logic [WIDTH+1:0] trial_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic             unused_trial_s;

    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dsr_mag_s;
    logic [WIDTH-1:0] quo_fin_s;
    logic [WIDTH-1:0] rem_fin_s;

    assign zero_div_s = (Divisor == {WIDTH{1'b0}});

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and accept decode
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    accept_s     = 1'b1;
                    state_next_s = zero_div_s ? S_FIX : S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_FIX:   state_next_s = S_DONE;
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // One shift-subtract step; the partial remainder is kept WIDTH+1 bits wide
    // so divisors above 2^(WIDTH-1) never lose the shifted-out MSB.
    always_comb begin
        trial_s    = {1'b0, rem_r, quo_r[WIDTH-1]} - {2'b00, dsr_r};
        quo_step_s = {quo_r[WIDTH-2:0], ~trial_s[WIDTH+1]};
        if (trial_s[WIDTH+1]) begin
            rem_step_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
        end else begin
            rem_step_s = trial_s[WIDTH-1:0];
        end
    end

    assign unused_trial_s = trial_s[WIDTH];

`ifdef DIV_SIGNED_EN
    logic q_neg_r;
    logic r_neg_r;
    logic q_neg_s;
    logic r_neg_s;

    // Operand magnitudes and result signs for DIV
    always_comb begin
        r_neg_s = Signed & Dividend[WIDTH-1];
        q_neg_s = r_neg_s ^ (Signed & Divisor[WIDTH-1]);
        if (r_neg_s) begin
            dvd_mag_s = -Dividend;
        end else begin
            dvd_mag_s = Dividend;
        end
        if (Signed & Divisor[WIDTH-1]) begin
            dsr_mag_s = -Divisor;
        end else begin
            dsr_mag_s = Divisor;
        end
        quo_fin_s = q_neg_r ? -quo_r : quo_r;
        rem_fin_s = r_neg_r ? -rem_r : rem_r;
    end

    // Sign flags; forced clear on divide by zero so the raw results pass through
    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (accept_s) begin
            q_neg_r <= q_neg_s & ~zero_div_s;
            r_neg_r <= r_neg_s & ~zero_div_s;
        end
    end
`else
    logic unused_signed_s;

    // Unsigned only: magnitudes are the raw operands, results need no fix-up
    always_comb begin
        dvd_mag_s = Dividend;
        dsr_mag_s = Divisor;
        quo_fin_s = quo_r;
        rem_fin_s = rem_r;
    end

    assign unused_signed_s = Signed;
`endif

    // Iteration datapath: Q holds the dividend and shifts quotient bits in from the right
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            dsr_r <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            dz_r  <= 1'b0;
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
            dz_r  <= zero_div_s;
            if (zero_div_s) begin
                quo_r <= {WIDTH{1'b1}};
                rem_r <= Dividend;
                dsr_r <= {WIDTH{1'b0}};
            end else begin
                quo_r <= dvd_mag_s;
                rem_r <= {WIDTH{1'b0}};
                dsr_r <= dsr_mag_s;
            end
        end else if (state_r == S_RUN) begin
            quo_r <= quo_step_s;
            rem_r <= rem_step_s;
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Registered outputs; results load on entry to S_DONE and hold afterwards
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= {WIDTH{1'b0}};
            Remainder <= {WIDTH{1'b0}};
            DivByZero <= 1'b0;
        end else begin
            Busy <= (state_next_s != S_IDLE);
            Done <= (state_next_s == S_DONE);
            if (state_r == S_FIX) begin
                Quotient  <= quo_fin_s;
                Remainder <= rem_fin_s;
                DivByZero <= dz_r;
            end
        end
    end

endmodule
